serial_adder: RTL

- Bit-serial N-bit adder built around a single 1-bit full-adder cell.
- A carry register feeds the cell's carry-in and captures its carry-out each cycle, so one operand bit pair is added per clock, LSB first.
- Sits beside the combinational adder datapath as the area-cheap option: same arithmetic result, one result word per WIDTH+1 cycles.
- Simple start/done handshake to the controlling logic.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/bit_adder_cell.sv | 16 +
 rtl/serial_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    // Controller states: waiting, shifting bits, presenting the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit counter width: it only has to reach WIDTH-1, where the run ends.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_adder_cell.sv
// Single 1-bit full adder; the only arithmetic in the serial adder.
module bit_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Plain full-adder equations, carry formed as generate | propagate&cin.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | ((a ^ b) & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first,
// through a single full-adder cell and a carry register.
//
// Handshake: start is sampled only on an edge where ready=1 (IDLE or DONE);
// that edge captures a, b and cin. busy is high while bits are being
// processed, and done is a one-cycle pulse when sum/cout/ovf have just been
// updated. Accepting start during DONE chains operations without a bubble.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output state_e           state_dbg
);

    localparam int           CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] ps_q;
    logic [WIDTH-1:0] ps_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             cell_s;
    logic             cell_co;

    bit_adder_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (cell_s),
        .cout (cell_co)
    );

    // Partial sum after this cycle's bit lands in the MSB; on the last bit
    // this is the complete result word.
    assign ps_d = {cell_s, ps_q[WIDTH-1:1]};

    // Controller and datapath: load on accept, shift one bit per RUN cycle,
    // publish the result on the final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            ps_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        ps_q    <= '0;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    ps_q    <= ps_d;
                    carry_q <= cell_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // carry_q is the carry into the MSB on this edge.
                        sum_q   <= ps_d;
                        cout_q  <= cell_co;
                        ovf_q   <= carry_q ^ cell_co;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (state_q != ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule
